// File: rtl/execute_mul_seq_if.sv
// Command/result bundle between the execute stage and the iterative multiplier.
// The slave side belongs to the multiplier; master is the issuing/writeback side.
interface execute_mul_seq_if;
  logic        iFLUSH;
  logic        iREQ;
  logic        oBUSY;
  logic [4:0]  iCMD;
  logic [31:0] iDATA_0;
  logic [31:0] iDATA_1;
  logic        oVALID;
  logic        iBUSY;
  logic [31:0] oDATA;
  logic [4:0]  oFLAGS;

  modport slave (
    input  iFLUSH, iREQ, iCMD, iDATA_0, iDATA_1, iBUSY,
    output oBUSY, oVALID, oDATA, oFLAGS
  );

  modport master (
    output iFLUSH, iREQ, iCMD, iDATA_0, iDATA_1, iBUSY,
    input  oBUSY, oVALID, oDATA, oFLAGS
  );
endinterface

// File: rtl/execute_mul_seq.sv
// 32x32 multiply over four 16x16 partial products; result in 5 cycles (1 on a zero operand).
// Result and flags are held in OUT while iBUSY is high; oBUSY blocks new commands until consumed.
module execute_mul_seq #(
  parameter bit         P_FAST_ZERO  = 1'b1,
  parameter logic [4:0] P_CMD_MULL   = 5'd0,
  parameter logic [4:0] P_CMD_MULH   = 5'd1,
  parameter logic [4:0] P_CMD_UMULL  = 5'd2,
  parameter logic [4:0] P_CMD_UMULH  = 5'd3
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  execute_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic        neg_q, high_q;
  logic [1:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] res_q;
  logic [4:0]  flg_q;

  logic        is_mulh, is_high, zero_in, accept;
  logic [31:0] a_abs, b_abs, pp;
  logic [15:0] a_half, b_half;
  logic [5:0]  shamt;
  logic [63:0] prod, r_fin;
  logic [36:0] sel;

  // Returns {word, flags}; low-word flags expose bit 32 as carry out of the low word.
  function automatic logic [36:0] pick(input logic [63:0] r, input logic high);
    logic zf;
    zf = (r == 64'd0);
    if (high) pick = {r[63:32], r[63], 1'b0, 1'b0, r[32], zf};
    else      pick = {r[31:0], r[31], r[31] ^ r[32], r[32], r[0], zf};
  endfunction

  // Unknown command codes fall through to the unsigned low-word behaviour.
  assign is_mulh = (bus.iCMD == P_CMD_MULH);
  assign is_high = is_mulh || (bus.iCMD == P_CMD_UMULH);
  assign a_abs   = (is_mulh && bus.iDATA_0[31]) ? -bus.iDATA_0 : bus.iDATA_0;
  assign b_abs   = (is_mulh && bus.iDATA_1[31]) ? -bus.iDATA_1 : bus.iDATA_1;
  assign zero_in = (bus.iDATA_0 == 32'd0) || (bus.iDATA_1 == 32'd0);
  assign accept  = (state == IDLE) && bus.iREQ && !bus.iFLUSH;

  // cnt[0] picks the a half, cnt[1] the b half; shift is 16 per selected upper half.
  assign a_half = cnt_q[0] ? a_q[31:16] : a_q[15:0];
  assign b_half = cnt_q[1] ? b_q[31:16] : b_q[15:0];
  assign pp     = a_half * b_half;
  assign shamt  = {cnt_q[0] & cnt_q[1], cnt_q[0] ^ cnt_q[1], 4'b0000};
  assign prod   = acc_q + ({32'd0, pp} << shamt);
  assign r_fin  = neg_q ? -prod : prod;
  assign sel    = pick(r_fin, high_q);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.iFLUSH) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.iREQ) state_nxt = (P_FAST_ZERO && zero_in) ? OUT : CALC;
        CALC:    if (cnt_q == 2'd3) state_nxt = OUT;
        OUT:     if (!bus.iBUSY) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.oBUSY  = (state != IDLE);
    bus.oVALID = (state == OUT);
    bus.oDATA  = res_q;
    bus.oFLAGS = flg_q;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      neg_q  <= 1'b0;
      high_q <= 1'b0;
      cnt_q  <= 2'd0;
      acc_q  <= 64'd0;
      res_q  <= 32'd0;
      flg_q  <= 5'd0;
    end else if (accept) begin
      a_q    <= a_abs;
      b_q    <= b_abs;
      neg_q  <= is_mulh && (bus.iDATA_0[31] ^ bus.iDATA_1[31]);
      high_q <= is_high;
      cnt_q  <= 2'd0;
      acc_q  <= 64'd0;
      if (P_FAST_ZERO && zero_in) begin
        res_q <= 32'd0;
        flg_q <= 5'b00001;
      end
    end else if ((state == CALC) && !bus.iFLUSH) begin
      acc_q <= prod;
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        res_q <= sel[36:5];
        flg_q <= sel[4:0];
      end
    end
  end

endmodule

// File: tb/tb_execute_mul_seq.sv
// Directed and randomized checks of execute_mul_seq against a full-width arithmetic model.
module tb_execute_mul_seq;
  localparam logic [4:0] MULL  = 5'd0;
  localparam logic [4:0] MULH  = 5'd1;
  localparam logic [4:0] UMULL = 5'd2;
  localparam logic [4:0] UMULH = 5'd3;

  logic iCLOCK = 1'b0;
  logic iRESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  execute_mul_seq_if bus ();

  execute_mul_seq #(.P_FAST_ZERO(1'b1)) dut (
    .iCLOCK (iCLOCK),
    .iRESET (iRESET),
    .bus    (bus.slave)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full 64-bit product straight from the operand values.
  task automatic ref_mul(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic [4:0] f);
    logic [63:0] r;
    longint sa, sb;
    bit hi;
    if (cmd == MULH) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 64'(sa * sb);
    end else begin
      r = {32'd0, a} * {32'd0, b};
    end
    hi = (cmd == MULH) || (cmd == UMULH);
    if (hi) begin
      d = r[63:32];
      f = {r[63], 1'b0, 1'b0, r[32], r == 64'd0};
    end else begin
      d = r[31:0];
      f = {r[31], r[31] != r[32], r[32], r[0], r == 64'd0};
    end
  endtask

  task automatic start_cmd(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b);
    @(negedge iCLOCK);
    chk("idle_obusy", bus.oBUSY, 0);
    bus.iREQ = 1'b1; bus.iCMD = cmd; bus.iDATA_0 = a; bus.iDATA_1 = b;
    @(posedge iCLOCK);
    #1 bus.iREQ = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge iCLOCK);
      lat++;
    end while (!bus.oVALID && lat < 12);
  endtask

  task automatic run_cmd(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
    logic [31:0] ed;
    logic [4:0]  ef;
    int lat;
    ref_mul(cmd, a, b, ed, ef);
    start_cmd(cmd, a, b);
    wait_valid(lat);
    chk("latency", lat, (a == 0 || b == 0) ? 1 : 5);
    chk("odata", bus.oDATA, ed);
    chk("oflags", bus.oFLAGS, ef);
    if (stall > 0) begin
      bus.iBUSY = 1'b1;
      bus.iREQ  = 1'b1;
      repeat (stall) begin
        @(negedge iCLOCK);
        chk("stall_valid", bus.oVALID, 1);
        chk("stall_obusy", bus.oBUSY, 1);
        chk("stall_data", bus.oDATA, ed);
        chk("stall_flags", bus.oFLAGS, ef);
      end
      bus.iBUSY = 1'b0;
      bus.iREQ  = 1'b0;
    end
    @(posedge iCLOCK);
    #1;
    chk("consumed_valid", bus.oVALID, 0);
    chk("consumed_obusy", bus.oBUSY, 0);
  endtask

  initial begin
    int lat;
    bus.iFLUSH = 1'b0; bus.iREQ = 1'b0; bus.iCMD = 5'd0;
    bus.iDATA_0 = 32'd0; bus.iDATA_1 = 32'd0; bus.iBUSY = 1'b0;
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    chk("rst_obusy", bus.oBUSY, 0);
    chk("rst_ovalid", bus.oVALID, 0);
    chk("rst_odata", bus.oDATA, 0);
    chk("rst_oflags", bus.oFLAGS, 0);
    iRESET = 1'b0;

    run_cmd(UMULL, 32'h3, 32'h5, 0);
    chk("small_flags_const", bus.oFLAGS, 5'b00010);
    run_cmd(UMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_cmd(MULL,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_cmd(MULH,  32'hFFFFFFFE, 32'h00000003, 0);
    run_cmd(MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_cmd(UMULL, 32'h80000000, 32'h00000002, 0);
    run_cmd(MULH,  32'h80000000, 32'h80000000, 0);
    run_cmd(MULH,  32'h80000000, 32'h00000001, 0);
    run_cmd(UMULL, 32'h0, 32'h12345678, 3);
    run_cmd(5'd9,  32'h1234ABCD, 32'h0F0F0F0F, 1);

    // Flush at cnt=2 (third CALC cycle): no result may appear.
    start_cmd(UMULH, 32'hDEADBEEF, 32'hCAFEF00D);
    repeat (3) @(negedge iCLOCK);
    bus.iFLUSH = 1'b1; bus.iREQ = 1'b1;
    @(posedge iCLOCK);
    #1 bus.iFLUSH = 1'b0; bus.iREQ = 1'b0;
    chk("flush_obusy", bus.oBUSY, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLOCK);
      chk("flush_novalid", bus.oVALID, 0);
    end
    run_cmd(UMULH, 32'hDEADBEEF, 32'hCAFEF00D, 0);

    // Reset while a result is being held.
    bus.iBUSY = 1'b1;
    start_cmd(MULH, 32'h7FFFFFFF, 32'h80000001);
    wait_valid(lat);
    chk("pre_rst_valid", bus.oVALID, 1);
    iRESET = 1'b1;
    #1;
    chk("async_rst_valid", bus.oVALID, 0);
    chk("async_rst_data", bus.oDATA, 0);
    chk("async_rst_flags", bus.oFLAGS, 0);
    chk("async_rst_obusy", bus.oBUSY, 0);
    bus.iBUSY = 1'b0;
    @(negedge iCLOCK);
    iRESET = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  c;
      logic [31:0] a, b;
      c = 5'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) a = {1'b1, 31'd0};
      run_cmd(c, a, b, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
